// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: one entry with an overflow-exception hold state.
// Optional overflow event counter is built only when OVF_COUNT_EN is defined.
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst,
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never waits on ready, and ready may depend on the consumer.
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] aluRslt,
  input  logic [15:0] aluRsltR15,
  input  logic        ovExcep,
  input  logic        aluCtrl,
  input  logic [3:0]  aluDecr,
  input  logic [3:0]  destReg,
  input  logic        regWrite,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [15:0] storeData,
  input  logic [15:0] pcIn,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [15:0] r15Data,
  output logic        r15Write,
  output logic [3:0]  destRegOut,
  output logic        regWriteOut,
  output logic        memReadOut,
  output logic        memWriteOut,
  output logic [15:0] storeDataOut,
  output logic        excReq,
  input  logic        excAck,
  output logic [15:0] epc,
  output logic [7:0]  ovfCount,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    EXC   = 2'd2
  } state_t;

  state_t state;
  logic   accept;
  logic   load;
  logic   take_exc;
  logic   hold;
  logic   is_mul_div;
  logic   is_rem;

  assign in_ready  = (state == EMPTY) | ((state == FULL) & out_ready);
  assign accept    = in_valid & in_ready & ~flush;
  assign load      = accept & ~ovExcep;
  assign take_exc  = accept & ovExcep;
  assign hold      = (state == FULL) & ~out_ready & ~flush;
  assign out_valid = (state == FULL);
  assign excReq    = (state == EXC);
  assign dbg_state = state;

  assign is_mul_div = ~aluCtrl & ((aluDecr == 4'b0100) | (aluDecr == 4'b0101));
  assign is_rem     = ~aluCtrl & (aluDecr == 4'b0101);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      result       <= '0;
      r15Data      <= '0;
      r15Write     <= 1'b0;
      destRegOut   <= '0;
      regWriteOut  <= 1'b0;
      memReadOut   <= 1'b0;
      memWriteOut  <= 1'b0;
      storeDataOut <= '0;
      epc          <= '0;
    end else begin
      case (state)
        EMPTY, FULL: begin
          if (load)          state <= FULL;
          else if (take_exc) state <= EXC;
          else if (!hold)    state <= EMPTY;
        end
        EXC: begin
          if (excAck) state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase

      if (load) begin
        result       <= is_rem ? aluRslt[31:16] : aluRslt[15:0];
        r15Data      <= is_mul_div ? aluRsltR15 : 16'h0000;
        r15Write     <= is_mul_div;
        destRegOut   <= destReg;
        regWriteOut  <= regWrite;
        memReadOut   <= memRead;
        memWriteOut  <= memWrite;
        storeDataOut <= storeData;
      end else if (!hold) begin
        // Side-effect enables must never be visible without a valid entry.
        r15Write    <= 1'b0;
        regWriteOut <= 1'b0;
        memReadOut  <= 1'b0;
        memWriteOut <= 1'b0;
      end

      if (take_exc) epc <= pcIn;
    end
  end

`ifdef OVF_COUNT_EN
  logic [7:0] ovf_cnt;

  always_ff @(posedge clk) begin
    if (rst)                             ovf_cnt <= '0;
    else if (take_exc && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
  end

  assign ovfCount = ovf_cnt;
`else
  assign ovfCount = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: table-driven stream with scoreboard, then directed
// back-pressure, overflow, flush and reset sequences.
module tb_ex_mem_stage;

  localparam int W = 56;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] aluRslt;
  logic [15:0] aluRsltR15;
  logic        ovExcep, aluCtrl;
  logic [3:0]  aluDecr, destReg;
  logic        regWrite, memRead, memWrite;
  logic [15:0] storeData, pcIn;
  logic        flush, out_valid, out_ready;
  logic [15:0] result, r15Data;
  logic        r15Write;
  logic [3:0]  destRegOut;
  logic        regWriteOut, memReadOut, memWriteOut;
  logic [15:0] storeDataOut;
  logic        excReq, excAck;
  logic [15:0] epc;
  logic [7:0]  ovfCount;
  logic [1:0]  dbg_state;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .aluRslt(aluRslt), .aluRsltR15(aluRsltR15), .ovExcep(ovExcep),
    .aluCtrl(aluCtrl), .aluDecr(aluDecr), .destReg(destReg),
    .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
    .storeData(storeData), .pcIn(pcIn), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .r15Data(r15Data), .r15Write(r15Write), .destRegOut(destRegOut),
    .regWriteOut(regWriteOut), .memReadOut(memReadOut),
    .memWriteOut(memWriteOut), .storeDataOut(storeDataOut),
    .excReq(excReq), .excAck(excAck), .epc(epc), .ovfCount(ovfCount),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic sb_on = 1'b0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic        alu_ctrl;
    logic [3:0]  alu_decr;
    logic [31:0] alu_rslt;
    logic [15:0] alu_r15;
    logic [3:0]  dest;
    logic        rw, mr, mw;
    logic [15:0] sdata;
    logic [15:0] exp_result;
    logic [15:0] exp_r15d;
    logic        exp_r15w;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; aluRslt = '0; aluRsltR15 = '0; ovExcep = 0; aluCtrl = 0;
    aluDecr = '0; destReg = '0; regWrite = 0; memRead = 0; memWrite = 0;
    storeData = '0; pcIn = '0; flush = 0; out_ready = 0; excAck = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_vec(input vec_t v);
    in_valid = 1; ovExcep = 0; flush = 0;
    aluCtrl = v.alu_ctrl; aluDecr = v.alu_decr; aluRslt = v.alu_rslt;
    aluRsltR15 = v.alu_r15; destReg = v.dest; regWrite = v.rw;
    memRead = v.mr; memWrite = v.mw; storeData = v.sdata;
  endtask

  // Offer one vector until accepted; out_ready optionally randomised.
  task automatic send(input vec_t v, input bit rnd_ready);
    bit done = 0;
    drive_vec(v);
    for (int t = 0; t < 50 && !done; t++) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (in_ready) begin
        exp_q.push_back({v.exp_result, v.exp_r15d, v.exp_r15w, v.dest,
                         v.rw, v.mr, v.mw, v.sdata});
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic simple_op(input logic [31:0] r, input logic [15:0] pc, input logic ov);
    in_valid = 1; aluCtrl = 1; aluDecr = 4'b0000; aluRslt = r; aluRsltR15 = 16'h0;
    ovExcep = ov; pcIn = pc; destReg = 4'h3; regWrite = 1; memRead = 0; memWrite = 0;
    storeData = 16'h00AA;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (!out_valid)
        check("ctrl_gated", {r15Write, regWriteOut, memReadOut, memWriteOut}, 4'b0);
      if (sb_on && out_valid) begin
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else begin
          check("sb_entry", {result, r15Data, r15Write, destRegOut, regWriteOut,
                             memReadOut, memWriteOut, storeDataOut}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    logic [7:0] exp_ovf;
`ifdef OVF_COUNT_EN
    exp_ovf = 8'd1;
`else
    exp_ovf = 8'd0;
`endif
    //          ctrl decr     rslt          r15      dst  rw mr mw sdata     result   r15d     r15w
    vecs[0] = '{1'b0, 4'b0000, 32'h0000_1234, 16'hABCD, 4'h1, 1, 0, 0, 16'h1111, 16'h1234, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 4'b0100, 32'h0002_0000, 16'h0002, 4'h2, 1, 0, 0, 16'h2222, 16'h0000, 16'h0002, 1'b1};
    vecs[2] = '{1'b0, 4'b0101, 32'h0007_0003, 16'h0011, 4'h3, 1, 0, 0, 16'h3333, 16'h0007, 16'h0011, 1'b1};
    vecs[3] = '{1'b1, 4'b0101, 32'h0007_0003, 16'h0011, 4'h4, 0, 1, 0, 16'h4444, 16'h0003, 16'h0000, 1'b0};
    vecs[4] = '{1'b1, 4'b0100, 32'hFFFF_8000, 16'h1234, 4'h5, 0, 0, 1, 16'h5555, 16'h8000, 16'h0000, 1'b0};
    vecs[5] = '{1'b0, 4'b0110, 32'hDEAD_BEEF, 16'h5555, 4'h6, 1, 1, 0, 16'h6666, 16'hBEEF, 16'h0000, 1'b0};
    vecs[6] = '{1'b0, 4'b0011, 32'h1234_FFFF, 16'h7777, 4'hF, 0, 0, 1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0};
    vecs[7] = '{1'b1, 4'b0000, 32'h8000_0001, 16'h0001, 4'h0, 1, 0, 1, 16'h0000, 16'h0001, 16'h0000, 1'b0};

    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_outs", {out_valid, excReq, result, r15Data, r15Write, destRegOut,
                       storeDataOut, epc, ovfCount}, '0);

    // Streamed vectors, zero-bubble, then with random back-pressure
    sb_on = 1;
    for (int i = 0; i < 8; i++) send(vecs[i], 1'b0);
    out_ready = 1; tick(); tick();
    check("drain1", exp_q.size(), 0);
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 8; i++) send(vecs[i], 1'b1);
    out_ready = 1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick();
    check("drain2", exp_q.size(), 0);
    sb_on = 0;
    idle_inputs(); do_reset();

    // Back-pressure with zero-bubble release
    simple_op(32'h0000_1234, 16'h0010, 0); out_ready = 0;
    tick();
    check("bp_full", {out_valid, result}, {1'b1, 16'h1234});
    simple_op(32'h0000_5678, 16'h0012, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      tick();
      check("bp_hold", {out_valid, result, regWriteOut, destRegOut}, {1'b1, 16'h1234, 1'b1, 4'h3});
    end
    out_ready = 1;
    tick();
    check("bp_no_bubble", {out_valid, result}, {1'b1, 16'h5678});

    // Overflow from FULL
    simple_op(32'h0000_9999, 16'h0040, 1);
    tick();
    check("ovf_state", {excReq, out_valid, epc, regWriteOut}, {1'b1, 1'b0, 16'h0040, 1'b0});
    check("ovf_count", ovfCount, exp_ovf);
    simple_op(32'h0000_4321, 16'h0050, 0); flush = 1;
    #1; check("exc_in_ready", in_ready, 0);
    tick();
    check("exc_flush_ignored", {excReq, out_valid, epc}, {1'b1, 1'b0, 16'h0040});
    flush = 0; tick();
    check("exc_in_ignored", {excReq, out_valid}, 2'b10);
    in_valid = 0; excAck = 1;
    tick();
    excAck = 0;
    check("exc_ack", {excReq, out_valid, in_ready}, 3'b001);

    // Flush from FULL drops held and incoming entries
    simple_op(32'h0000_0A0A, 16'h0060, 0); out_ready = 0;
    tick();
    check("fl_full", {out_valid, result}, {1'b1, 16'h0A0A});
    simple_op(32'h0000_0B0B, 16'h0062, 0); out_ready = 1; flush = 1;
    tick();
    check("fl_empty", {out_valid, regWriteOut, in_ready}, 3'b001);
    flush = 1; tick();
    check("fl_in_empty", out_valid, 0);
    flush = 0; in_valid = 0; tick();
    check("fl_dropped", out_valid, 0);

    // Reset while FULL
    simple_op(32'h0000_0C0C, 16'h0070, 0); out_ready = 0;
    tick();
    check("rf_full", out_valid, 1);
    rst = 1; flush = 0; tick(); rst = 0; in_valid = 0;
    check("rf_outs", {out_valid, excReq, result, r15Data, r15Write, destRegOut,
                      regWriteOut, memReadOut, memWriteOut, storeDataOut, epc, ovfCount}, '0);
    check("rf_in_ready", in_ready, 1);

    // Reset while EXC, with excAck also high
    simple_op(32'h0000_0D0D, 16'h0080, 1);
    tick();
    check("re_exc", {excReq, epc}, {1'b1, 16'h0080});
    in_valid = 0; rst = 1; excAck = 1; tick(); rst = 0; excAck = 0;
    check("re_outs", {out_valid, excReq, epc, ovfCount, result}, '0);
    check("re_in_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset: clk and rst.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- aluRslt  in  32  ALU result
- aluRsltR15  in  16  ALU R15 side result (mul high / div quotient)
- ovExcep  in  1  ALU signed-overflow exception
- aluCtrl  in  1  ALU control bit
- aluDecr  in  4  ALU operation decode
- destReg  in  4  destination register
- regWrite, memRead, memWrite  in  1 each  control bits
- storeData  in  16  store operand
- pcIn  in  16  PC of the instruction
- flush  in  1  discard the held and incoming instruction
- out_valid  out  1  the memory stage has a valid entry
- out_ready  in  1  the memory stage accepts the entry
- result  out  16  address or result
- r15Data  out  16  R15 write data
- r15Write  out  1  R15 write enable
- destRegOut  out  4  registered destReg
- regWriteOut, memReadOut, memWriteOut  out  1 each  registered control bits
- storeDataOut  out  16  registered storeData
- excReq  out  1  overflow exception pending
- excAck  in  1  controller acknowledges the exception
- epc  out  16  PC of the faulting instruction
- ovfCount  out  8  overflow event count (see Configuration)

Function
REQ-003 SHALL implement a one-entry register with three states: EMPTY, FULL and EXC.
REQ-004 SHALL define accept as in_valid AND in_ready AND NOT flush.
REQ-005 SHALL drive in_ready as follows: 1 in EMPTY; out_ready in FULL; 0 in EXC.
REQ-006 SHALL drive out_valid=1 only in FULL, and excReq=1 only in EXC.
REQ-007 EMPTY: accept with ovExcep=0 -> FULL with the entry captured; accept with ovExcep=1 -> EXC with epc<=pcIn; otherwise stay in EMPTY.
REQ-008 FULL: with out_ready=0, the state and all outputs SHALL hold.
REQ-009 FULL with out_ready=1: accept with ovExcep=0 -> FULL with the new entry (zero-bubble); accept with ovExcep=1 -> EXC; no accept -> EMPTY.
REQ-010 EXC: the stage SHALL hold until excAck=1, then go to EMPTY; in_valid SHALL be ignored while in EXC.
REQ-011 flush=1 SHALL force EMPTY from EMPTY or FULL on the next edge, discard the incoming instruction, and take priority over accept and out_ready.
REQ-012 flush SHALL be ignored in EXC.
REQ-013 A faulting instruction SHALL never reach the outputs; regWriteOut, memReadOut, memWriteOut and r15Write SHALL be 0 whenever out_valid=0.
REQ-014 The captured result SHALL be aluRslt[31:16] when aluCtrl=0 and aluDecr=4'b0101 (divide remainder), and aluRslt[15:0] otherwise.
REQ-015 The captured r15Write SHALL be 1 iff aluCtrl=0 and aluDecr is 4'b0100 (multiply) or 4'b0101 (divide); r15Data<=aluRsltR15 in that case, else r15Data<=0.
REQ-016 Latency SHALL be 1 cycle from accept to out_valid.
REQ-017 There SHALL be no combinational path from ALU data inputs to any output; the only combinational output path is out_ready -> in_ready.

Reset
REQ-018 On rst=1 at a rising edge the state SHALL become EMPTY and every output register SHALL clear to 0: result, r15Data, r15Write, destRegOut, all control outputs, storeDataOut, epc, excReq, out_valid, ovfCount.
REQ-019 rst SHALL override flush, excAck and accept; a pending exception is lost on reset.
REQ-020 in_ready SHALL read 1 in the first cycle after reset.

Configuration
REQ-021 With macro OVF_COUNT_EN defined, ovfCount SHALL increment by 1 on each transition into EXC and saturate at 8'hFF.
REQ-022 With OVF_COUNT_EN undefined, ovfCount SHALL be tied to 0 and no counter logic is built.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Add: aluRslt=32'h0000_1234, ovExcep=0, out_ready=1 -> next cycle out_valid=1, result=16'h1234, r15Write=0.
- Multiply: aluCtrl=0, aluDecr=4'b0100, aluRslt=32'h0002_0000, aluRsltR15=16'h0002 -> r15Write=1, r15Data=16'h0002, result=16'h0000.
- Back-pressure: out_ready=0 for 3 cycles with FULL -> outputs stable, in_ready=0; with out_ready=1 and in_valid=1 in the same cycle -> new entry next cycle with no bubble.
- Overflow: ovExcep=1, pcIn=16'h0040 -> excReq=1, epc=16'h0040, out_valid=0, in_ready=0 until excAck; excAck -> EMPTY; ovfCount=1 when OVF_COUNT_EN is defined.
- Flush: FULL with flush=1 and in_valid=1 -> EMPTY next cycle, out_valid=0, incoming instruction dropped; flush in EXC -> excReq stays 1.
- Reset mid-operation: rst in FULL or EXC -> all outputs 0 and in_ready=1 next cycle.
